// File: rtl/bsg_manycore_pkt_decode_pkg.sv
// -----------------------------------------------------------------------------
// bsg_manycore_pkt_decode_pkg
//
// Shared definitions for the staged manycore packet decoder.
// - Opcode enum for the two opcodes the decoder retires locally.
// - Config address map: freeze bit, arbitration config, then the general
//   config register bank starting at cfg_addr_gen_base.
// - packet_width(): total width of a packed manycore packet.
//
// Packet layout, MSB to LSB:
//   addr | op | op_ex (data/8) | payload | src_y | src_x | dst_y | dst_x
// -----------------------------------------------------------------------------
package bsg_manycore_pkt_decode_pkg;

  localparam int op_width_gp = 2;

  typedef enum logic [op_width_gp-1:0] {
    e_op_remote_store = 2'd1,
    e_op_config       = 2'd2
  } bsg_manycore_pkt_op_e;

  localparam int cfg_addr_freeze   = 0;
  localparam int cfg_addr_arb      = 1;
  localparam int cfg_addr_gen_base = 2;

  function automatic int packet_width(input int addr_w, input int data_w,
                                      input int x_w, input int y_w);
    return addr_w + op_width_gp + (data_w / 8) + data_w + 2 * y_w + 2 * x_w;
  endfunction

endpackage

// File: rtl/bsg_manycore_pkt_decode_cfg_regs.sv
// -----------------------------------------------------------------------------
// bsg_manycore_pkt_decode_cfg_regs
//
// Local configuration state written by accepted config packets.
//
// Ports:
//   clk_i, reset_i : clock, asynchronous active-high reset
//   we_i           : write strobe (accepted config packet)
//   addr_i         : config address
//   data_i         : config data
//   hit_o          : addr_i maps to an implemented register (combinational)
//   freeze_o       : freeze bit, resets to 1 so tiles come up frozen
//   arb_cfg_o      : arbitration config register
//   cfg_o          : general config bank, reg i at [i*data_width_p +: data_width_p]
// -----------------------------------------------------------------------------
module bsg_manycore_pkt_decode_cfg_regs
  import bsg_manycore_pkt_decode_pkg::*;
#(
  parameter int data_width_p   = 32,
  parameter int addr_width_p   = 16,
  parameter int num_cfg_regs_p = 4
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic                                   we_i,
  input  logic [addr_width_p-1:0]                addr_i,
  input  logic [data_width_p-1:0]                data_i,
  output logic                                   hit_o,
  output logic                                   freeze_o,
  output logic [data_width_p-1:0]                arb_cfg_o,
  output logic [num_cfg_regs_p*data_width_p-1:0] cfg_o
);

  logic                      w_freeze_hit;
  logic                      w_arb_hit;
  logic [num_cfg_regs_p-1:0] w_gen_hit;
  logic                      r_freeze;
  logic [data_width_p-1:0]   r_arb_cfg;

  assign w_freeze_hit = (addr_i == addr_width_p'(cfg_addr_freeze));
  assign w_arb_hit    = (addr_i == addr_width_p'(cfg_addr_arb));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_freeze <= 1'b1;
    end else if (we_i && w_freeze_hit) begin
      r_freeze <= data_i[0];
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_arb_cfg <= '0;
    end else if (we_i && w_arb_hit) begin
      r_arb_cfg <= data_i;
    end
  end

  // One register per generate block keeps each register single-driven.
  for (genvar gi = 0; gi < num_cfg_regs_p; gi++) begin : g_cfg
    logic [data_width_p-1:0] r_cfg;

    assign w_gen_hit[gi] = (addr_i == addr_width_p'(cfg_addr_gen_base + gi));

    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        r_cfg <= '0;
      end else if (we_i && w_gen_hit[gi]) begin
        r_cfg <= data_i;
      end
    end

    assign cfg_o[gi*data_width_p +: data_width_p] = r_cfg;
  end

  assign hit_o     = w_freeze_hit | w_arb_hit | (|w_gen_hit);
  assign freeze_o  = r_freeze;
  assign arb_cfg_o = r_arb_cfg;

endmodule

// File: rtl/bsg_manycore_pkt_decoder_staged.sv
// -----------------------------------------------------------------------------
// bsg_manycore_pkt_decoder_staged
//
// Registered, flow-controlled packet decoder for the manycore endpoint.
// Remote stores go to a one-entry output register (valid/yumi), config
// packets update local config state, everything else is flagged unknown.
//
// Ports:
//   clk_i, reset_i  : clock, asynchronous active-high reset
//   v_i, data_i     : input packet and valid
//   ready_o         : decoder accepts a packet this cycle (0 during reset)
//   v_o, yumi_i     : pending remote store and its consume strobe
//   data_o, addr_o, mask_o : pending store fields
//   freeze_o, arb_cfg_o, cfg_o : config state
//   unknown_v_o     : one-cycle pulse per accepted unknown packet
//   unknown_cnt_o   : saturating unknown-packet count
//
// Build option: BSG_MANYCORE_PKT_DECODE_UNKNOWN_CNT_EN builds the saturating
// unknown counter; when undefined unknown_cnt_o is tied to zero.
// -----------------------------------------------------------------------------
module bsg_manycore_pkt_decoder_staged
  import bsg_manycore_pkt_decode_pkg::*;
#(
  parameter int x_cord_width_p      = 4,
  parameter int y_cord_width_p      = 4,
  parameter int data_width_p        = 32,
  parameter int addr_width_p        = 16,
  parameter int num_cfg_regs_p      = 4,
  parameter int unknown_cnt_width_p = 8,
  localparam int packet_width_lp    = packet_width(addr_width_p, data_width_p,
                                                   x_cord_width_p, y_cord_width_p)
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic                                   v_i,
  input  logic [packet_width_lp-1:0]             data_i,
  output logic                                   ready_o,
  output logic                                   v_o,
  input  logic                                   yumi_i,
  output logic [data_width_p-1:0]                data_o,
  output logic [addr_width_p-1:0]                addr_o,
  output logic [(data_width_p>>3)-1:0]           mask_o,
  output logic                                   freeze_o,
  output logic [data_width_p-1:0]                arb_cfg_o,
  output logic [num_cfg_regs_p*data_width_p-1:0] cfg_o,
  output logic                                   unknown_v_o,
  output logic [unknown_cnt_width_p-1:0]         unknown_cnt_o
);

  localparam int lp_mask_width = data_width_p >> 3;
  localparam int lp_data_lsb   = 2 * x_cord_width_p + 2 * y_cord_width_p;
  localparam int lp_mask_lsb   = lp_data_lsb + data_width_p;
  localparam int lp_op_lsb     = lp_mask_lsb + lp_mask_width;
  localparam int lp_addr_lsb   = lp_op_lsb + op_width_gp;

  logic [op_width_gp-1:0]   w_op;
  logic [addr_width_p-1:0]  w_addr;
  logic [data_width_p-1:0]  w_data;
  logic [lp_mask_width-1:0] w_mask;
  logic                     w_unused_cords;
  logic                     w_accept;
  logic                     w_is_store;
  logic                     w_is_config;
  logic                     w_cfg_hit;
  logic                     w_unknown;

  logic                     r_v;
  logic [data_width_p-1:0]  r_data;
  logic [addr_width_p-1:0]  r_addr;
  logic [lp_mask_width-1:0] r_mask;
  logic                     r_unknown_v;

  assign w_op   = data_i[lp_op_lsb   +: op_width_gp];
  assign w_addr = data_i[lp_addr_lsb +: addr_width_p];
  assign w_data = data_i[lp_data_lsb +: data_width_p];
  assign w_mask = data_i[lp_mask_lsb +: lp_mask_width];

  // Source/destination coordinates are not needed once the packet is here.
  assign w_unused_cords = ^data_i[lp_data_lsb-1:0];

  // One accept rule for every opcode: a config packet can never overtake a
  // store still waiting in the output register.
  assign ready_o  = ~reset_i & (~r_v | yumi_i);
  assign w_accept = v_i & ready_o;

  assign w_is_store  = (w_op == e_op_remote_store);
  assign w_is_config = (w_op == e_op_config);
  assign w_unknown   = w_accept & ~w_is_store & ~(w_is_config & w_cfg_hit);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_v    <= 1'b0;
      r_data <= '0;
      r_addr <= '0;
      r_mask <= '0;
    end else if (w_accept && w_is_store) begin
      // Also covers reload in the same cycle the old store is consumed.
      r_v    <= 1'b1;
      r_data <= w_data;
      r_addr <= w_addr;
      r_mask <= w_mask;
    end else if (yumi_i) begin
      r_v <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_unknown_v <= 1'b0;
    end else begin
      r_unknown_v <= w_unknown;
    end
  end

`ifdef BSG_MANYCORE_PKT_DECODE_UNKNOWN_CNT_EN
  logic [unknown_cnt_width_p-1:0] r_unknown_cnt;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_unknown_cnt <= '0;
    end else if (w_unknown && (r_unknown_cnt != '1)) begin
      r_unknown_cnt <= r_unknown_cnt + 1'b1;
    end
  end

  assign unknown_cnt_o = r_unknown_cnt;
`else
  assign unknown_cnt_o = '0;
`endif

  bsg_manycore_pkt_decode_cfg_regs #(
    .data_width_p   (data_width_p),
    .addr_width_p   (addr_width_p),
    .num_cfg_regs_p (num_cfg_regs_p)
  ) cfg_regs (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .we_i      (w_accept & w_is_config),
    .addr_i    (w_addr),
    .data_i    (w_data),
    .hit_o     (w_cfg_hit),
    .freeze_o  (freeze_o),
    .arb_cfg_o (arb_cfg_o),
    .cfg_o     (cfg_o)
  );

  assign v_o         = r_v;
  assign data_o      = r_data;
  assign addr_o      = r_addr;
  assign mask_o      = r_mask;
  assign unknown_v_o = r_unknown_v;

endmodule

// File: tb/tb_bsg_manycore_pkt_decoder_staged.sv
// -----------------------------------------------------------------------------
// Testbench for bsg_manycore_pkt_decoder_staged: directed cases with literal
// expectations, then random traffic against a packet-level reference model.
// Honours BSG_MANYCORE_PKT_DECODE_UNKNOWN_CNT_EN for the expected counter.
// -----------------------------------------------------------------------------
module tb_bsg_manycore_pkt_decoder_staged;

  localparam int X  = 4;
  localparam int Y  = 4;
  localparam int D  = 32;
  localparam int A  = 8;
  localparam int N  = 4;
  localparam int CW = 8;
  localparam int PW = A + 2 + D / 8 + D + 2 * X + 2 * Y;

  logic           clk = 1'b0;
  logic           reset_i;
  logic           v_i;
  logic [PW-1:0]  data_i;
  logic           ready_o;
  logic           v_o;
  logic           yumi_i;
  logic [D-1:0]   data_o;
  logic [A-1:0]   addr_o;
  logic [D/8-1:0] mask_o;
  logic           freeze_o;
  logic [D-1:0]   arb_cfg_o;
  logic [N*D-1:0] cfg_o;
  logic           unknown_v_o;
  logic [CW-1:0]  unknown_cnt_o;

  always #5 clk = ~clk;

  bsg_manycore_pkt_decoder_staged #(
    .x_cord_width_p      (X),
    .y_cord_width_p      (Y),
    .data_width_p        (D),
    .addr_width_p        (A),
    .num_cfg_regs_p      (N),
    .unknown_cnt_width_p (CW)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .v_i           (v_i),
    .data_i        (data_i),
    .ready_o       (ready_o),
    .v_o           (v_o),
    .yumi_i        (yumi_i),
    .data_o        (data_o),
    .addr_o        (addr_o),
    .mask_o        (mask_o),
    .freeze_o      (freeze_o),
    .arb_cfg_o     (arb_cfg_o),
    .cfg_o         (cfg_o),
    .unknown_v_o   (unknown_v_o),
    .unknown_cnt_o (unknown_cnt_o)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 1'b0;

  // Reference model: the architectural state after each clock edge.
  bit           m_freeze;
  logic [D-1:0] m_arb;
  logic [D-1:0] m_cfg [N];
  bit           m_v;
  logic [D-1:0] m_data;
  logic [A-1:0] m_addr;
  logic [3:0]   m_mask;
  bit           m_unk_v;
  int           m_cnt;

  task automatic chk(input string name, input logic [N*D-1:0] act, input logic [N*D-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_freeze = 1'b1;
    m_arb    = '0;
    for (int i = 0; i < N; i++) m_cfg[i] = '0;
    m_v      = 1'b0;
    m_data   = '0;
    m_addr   = '0;
    m_mask   = '0;
    m_unk_v  = 1'b0;
    m_cnt    = 0;
  endtask

  function automatic logic [N*D-1:0] model_cfg_flat();
    logic [N*D-1:0] f;
    for (int i = 0; i < N; i++) f[i*D +: D] = m_cfg[i];
    return f;
  endfunction

  function automatic logic [CW-1:0] exp_cnt();
`ifdef BSG_MANYCORE_PKT_DECODE_UNKNOWN_CNT_EN
    return CW'(m_cnt);
`else
    return '0;
`endif
  endfunction

  // Compare every registered output against the model each cycle.
  always @(negedge clk) begin
    if (checking) begin
      chk("v_o",           v_o,           m_v);
      chk("data_o",        data_o,        m_data);
      chk("addr_o",        addr_o,        m_addr);
      chk("mask_o",        mask_o,        m_mask);
      chk("freeze_o",      freeze_o,      m_freeze);
      chk("arb_cfg_o",     arb_cfg_o,     m_arb);
      chk("cfg_o",         cfg_o,         model_cfg_flat());
      chk("unknown_v_o",   unknown_v_o,   m_unk_v);
      chk("unknown_cnt_o", unknown_cnt_o, exp_cnt());
    end
  end

  // Drive one cycle of stimulus (called just after a negedge), step the model
  // at the posedge, and return just after the following negedge.
  task automatic send(input bit v, input logic [1:0] op, input logic [3:0] mask,
                      input logic [A-1:0] addr, input logic [D-1:0] data, input bit yumi);
    bit rdy;
    bit acc;
    bit unk;
    v_i    = v;
    yumi_i = yumi;
    data_i = {addr, op, mask, data, 16'($urandom)};
    #1;
    rdy = !reset_i && (!m_v || yumi);
    chk("ready_o", ready_o, rdy);
    if (yumi) chk("yumi_needs_v_o", v_o, 1'b1);
    @(posedge clk);
    acc = v && rdy;
    unk = 1'b0;
    if (reset_i) begin
      model_reset();
    end else begin
      if (m_v && yumi) m_v = 1'b0;
      if (acc) begin
        if (op == 2'd1) begin
          m_v    = 1'b1;
          m_data = data;
          m_addr = addr;
          m_mask = mask;
        end else if (op == 2'd2) begin
          if (addr == 0)                    m_freeze = data[0];
          else if (addr == 1)               m_arb = data;
          else if (addr >= 2 && addr < 2 + N) m_cfg[addr - 2] = data;
          else                              unk = 1'b1;
        end else begin
          unk = 1'b1;
        end
        $display("pkt op=%0d addr=%0h data=%0h mask=%0h unknown=%0d", op, addr, data, mask, unk);
      end
      m_unk_v = unk;
      if (unk && m_cnt < (1 << CW) - 1) m_cnt++;
    end
    @(negedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit            rv;
    logic [1:0]    rop;
    logic [A-1:0]  raddr;
    reset_i = 1'b1;
    v_i     = 1'b0;
    yumi_i  = 1'b0;
    data_i  = '0;
    model_reset();
    @(negedge clk);
    #1;
    checking = 1'b1;

    // Reset state.
    chk("rst_freeze", freeze_o, 1'b1);
    chk("rst_v",      v_o,      1'b0);
    chk("rst_cfg",    cfg_o,    '0);
    chk("rst_ready",  ready_o,  1'b0);
    send(1, 2'd1, 4'hF, 8'h10, 32'h1111, 0);  // ignored while in reset
    chk("rst_no_accept", v_o, 1'b0);
    reset_i = 1'b0;

    // Unfreeze.
    send(1, 2'd2, 4'h0, 8'h00, 32'h0, 0);
    chk("unfreeze", freeze_o, 1'b0);
    send(1, 2'd2, 4'h0, 8'h01, 32'hA5A5_0001, 0);
    chk("arb_write", arb_cfg_o, 32'hA5A5_0001);

    // Store held under back-pressure, then back-to-back reload.
    send(1, 2'd1, 4'hF, 8'h10, 32'hDEAD_BEEF, 0);
    chk("st1_v",    v_o,    1'b1);
    chk("st1_data", data_o, 32'hDEAD_BEEF);
    chk("st1_addr", addr_o, 8'h10);
    chk("st1_mask", mask_o, 4'hF);
    send(1, 2'd2, 4'h0, 8'h02, 32'h9999, 0);  // blocked behind the store
    chk("blocked_ready", ready_o, 1'b0);
    chk("blocked_cfg",   cfg_o,   '0);
    send(1, 2'd1, 4'h3, 8'h20, 32'hCAFE_F00D, 1);
    chk("st2_v",    v_o,    1'b1);
    chk("st2_data", data_o, 32'hCAFE_F00D);
    send(0, 2'd0, 4'h0, 8'h00, 32'h0, 1);
    chk("drain_v", v_o, 1'b0);

    // General config bank and out-of-range address.
    send(1, 2'd2, 4'h0, 8'h05, 32'h1234, 0);
    chk("cfg3", cfg_o, {32'h1234, 96'h0});
    send(1, 2'd2, 4'h0, 8'h06, 32'hFFFF, 0);
    chk("cfg_oob_unknown", unknown_v_o, 1'b1);
    chk("cfg_oob_hold",    cfg_o, {32'h1234, 96'h0});
    send(0, 2'd0, 4'h0, 8'h00, 32'h0, 0);
    chk("unknown_pulse_end", unknown_v_o, 1'b0);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      rv    = ($urandom_range(0, 3) != 0);
      rop   = 2'($urandom_range(0, 3));
      raddr = ($urandom_range(0, 7) == 0) ? A'($urandom) : A'($urandom_range(0, 7));
      send(rv, rop, 4'($urandom), raddr, $urandom, m_v ? bit'($urandom_range(0, 1)) : 1'b0);
    end

    // Counter saturation.
    for (int i = 0; i < 260; i++) begin
      send(1, 2'd3, 4'($urandom), A'($urandom), $urandom, m_v);
    end
`ifdef BSG_MANYCORE_PKT_DECODE_UNKNOWN_CNT_EN
    chk("cnt_saturated", unknown_cnt_o, 8'hFF);
`else
    chk("cnt_disabled", unknown_cnt_o, 8'h00);
`endif

    // Asynchronous reset with a store pending.
    send(1, 2'd2, 4'h0, 8'h01, 32'h77, m_v);
    chk("arb_before_rst", arb_cfg_o, 32'h77);
    send(1, 2'd1, 4'hF, 8'h33, 32'h55, 0);
    chk("pending_before_rst", v_o, 1'b1);
    #2;
    reset_i = 1'b1;
    model_reset();
    #1;
    chk("async_rst_v",      v_o,       1'b0);
    chk("async_rst_freeze", freeze_o,  1'b1);
    chk("async_rst_arb",    arb_cfg_o, '0);
    @(negedge clk);
    #1;
    send(0, 2'd0, 4'h0, 8'h00, 32'h0, 0);
    reset_i = 1'b0;
    send(0, 2'd0, 4'h0, 8'h00, 32'h0, 0);
    send(1, 2'd1, 4'h1, 8'h44, 32'h66, 0);
    chk("post_rst_store", data_o, 32'h66);

    checking = 1'b0;
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
